debounce_multi: RTL

DEBOUNCE_MULTI -- requirements
Module: debounce_multi

---
 rtl/debounce_multi.sv | 91 +++++++++
 1 files changed

// File: rtl/debounce_multi.sv
// Multi-channel input debouncer: 2-flop synchronizer, per-channel stability counter,
// registered edge pulses. Optional sticky events + irq under DEBOUNCE_MULTI_EVT_IRQ_EN.
module debounce_multi #(
    parameter int   NUM_CH   = 2,
    parameter int   DB_CNT   = 25,
    parameter logic INIT_VAL = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] din,
    output logic [NUM_CH-1:0] dout,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse,
    output logic [NUM_CH-1:0] evt_status,
    input  logic [NUM_CH-1:0] evt_clr,
    input  logic [NUM_CH-1:0] irq_mask,
    output logic              irq
);

    localparam int               CNT_W   = $clog2(DB_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CNT - 1);

    logic [NUM_CH-1:0] s1;
    logic [NUM_CH-1:0] s2;
    logic [CNT_W-1:0]  cnt     [NUM_CH];
    logic [CNT_W-1:0]  cnt_nxt [NUM_CH];
    logic [NUM_CH-1:0] dout_nxt;

    // Counter only runs while the synchronized level disagrees with dout;
    // agreement at any point restarts the stability window.
    always_comb begin
        dout_nxt = dout;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_nxt[i] = '0;
            if (s2[i] != dout[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    dout_nxt[i] = s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1         <= {NUM_CH{INIT_VAL}};
            s2         <= {NUM_CH{INIT_VAL}};
            dout       <= {NUM_CH{INIT_VAL}};
            rise_pulse <= '0;
            fall_pulse <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            // stage 1/2: synchronizer
            s1         <= din;
            s2         <= s1;
            // stage 3: debounced level and its edge pulses
            dout       <= dout_nxt;
            rise_pulse <= dout_nxt & ~dout;
            fall_pulse <= ~dout_nxt & dout;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

`ifdef DEBOUNCE_MULTI_EVT_IRQ_EN
    logic [NUM_CH-1:0] evt_q;

    // A new edge event outranks a clear arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_q <= '0;
        end else begin
            evt_q <= (evt_q & ~evt_clr) | rise_pulse | fall_pulse;
        end
    end

    assign evt_status = evt_q;
    assign irq        = |(evt_q & irq_mask);
`else
    logic unused_evt_in;

    assign unused_evt_in = ^{evt_clr, irq_mask};
    assign evt_status    = '0;
    assign irq           = 1'b0;
`endif

endmodule
